// File: rtl/sstv_pkg.sv
// Shared constants, state encoding and mode timing lookup for the SSTV frame sequencer.
package sstv_pkg;

  localparam int unsigned TICK_W       = 32;
  localparam int unsigned FREQ_W       = 12;
  localparam int unsigned VIS_W        = 7;
  localparam int unsigned MODE_W       = 2;
  localparam int unsigned CHAN_W       = 2;
  localparam int unsigned X_W          = 9;
  localparam int unsigned Y_W          = 8;
  localparam int unsigned PIX_PER_CHAN = 320;

  typedef enum logic [6:0] {
    S_IDLE   = 7'b000_0001,
    S_LOOKUP = 7'b000_0010,
    S_SYNC   = 7'b000_0100,
    S_PORCH  = 7'b000_1000,
    S_SCAN   = 7'b001_0000,
    S_FINISH = 7'b010_0000,
    S_DRAIN  = 7'b100_0000
  } state_t;

  localparam logic [MODE_W-1:0] MODE_M1 = 2'd0;
  localparam logic [MODE_W-1:0] MODE_S1 = 2'd1;

  localparam logic [VIS_W-1:0] VIS_M1 = 7'd44;
  localparam logic [VIS_W-1:0] VIS_S1 = 7'd60;

  localparam logic [FREQ_W-1:0] FREQ_1200HZ = 12'd1200;

  localparam logic [TICK_W-1:0] M1_SYNC_REAL  = 32'd486_200;
  localparam logic [TICK_W-1:0] M1_SYNC_SIM   = 32'd486;
  localparam logic [TICK_W-1:0] M1_PORCH_REAL = 32'd57_200;
  localparam logic [TICK_W-1:0] M1_PORCH_SIM  = 32'd57;
  localparam logic [TICK_W-1:0] M1_PIXEL_REAL = 32'd45_760;
  localparam logic [TICK_W-1:0] M1_PIXEL_SIM  = 32'd45;
  localparam logic [TICK_W-1:0] S1_SYNC_REAL  = 32'd900_000;
  localparam logic [TICK_W-1:0] S1_SYNC_SIM   = 32'd900;
  localparam logic [TICK_W-1:0] S1_PORCH_REAL = 32'd150_000;
  localparam logic [TICK_W-1:0] S1_PORCH_SIM  = 32'd150;
  localparam logic [TICK_W-1:0] S1_PIXEL_REAL = 32'd43_200;
  localparam logic [TICK_W-1:0] S1_PIXEL_SIM  = 32'd43;

  typedef enum logic [1:0] {TK_SYNC, TK_PORCH, TK_PIXEL, TK_SCAN} tick_kind_t;

  // Tick length of one schedule segment for a mode; SCAN covers a whole channel.
  function automatic logic [TICK_W-1:0] mode_ticks(input logic [MODE_W-1:0] mode,
                                                   input logic sim,
                                                   input tick_kind_t kind);
    logic [TICK_W-1:0] sync_t;
    logic [TICK_W-1:0] porch_t;
    logic [TICK_W-1:0] pix_t;
    logic [TICK_W-1:0] t;
    if (mode == MODE_S1) begin
      sync_t  = sim ? S1_SYNC_SIM  : S1_SYNC_REAL;
      porch_t = sim ? S1_PORCH_SIM : S1_PORCH_REAL;
      pix_t   = sim ? S1_PIXEL_SIM : S1_PIXEL_REAL;
    end else begin
      sync_t  = sim ? M1_SYNC_SIM  : M1_SYNC_REAL;
      porch_t = sim ? M1_PORCH_SIM : M1_PORCH_REAL;
      pix_t   = sim ? M1_PIXEL_SIM : M1_PIXEL_REAL;
    end
    case (kind)
      TK_SYNC:  t = sync_t;
      TK_PORCH: t = porch_t;
      TK_PIXEL: t = pix_t;
      default:  t = TICK_W'(PIX_PER_CHAN) * pix_t;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sstv_tick_timer.sv
// Loadable down-counter: done flags the last tick of a segment, mid flags tick len/2.
module sstv_tick_timer
  import sstv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [TICK_W-1:0] i_len,
  output logic              o_mid_c,
  output logic              o_done_c
);

  logic [TICK_W-1:0] r_cnt;
  logic [TICK_W-1:0] r_mid_cnt;

  // Count value c corresponds to elapsed tick (len - c + 1).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_mid_cnt <= '0;
    end else if (i_load) begin
      r_cnt     <= i_len;
      r_mid_cnt <= i_len - (i_len >> 1) + TICK_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TICK_W'(1);
    end
  end

  assign o_done_c = (r_cnt == TICK_W'(1));
  assign o_mid_c  = (r_cnt != '0) && (r_cnt == r_mid_cnt);

endmodule

// File: rtl/sstv_frame_seq.sv
// SSTV frame sequencer: picks mode timing from the VIS code, walks SYNC/PORCH/SCAN
// per line, emits pixel strobes and supervises sync, requesting recalibration at frame end.
module sstv_frame_seq
  import sstv_pkg::*;
#(
  parameter int          simulate = 0,
  parameter int unsigned LINES    = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [FREQ_W-1:0] i_freq,
  input  logic [VIS_W-1:0]  i_vis_code,
  input  logic              i_vis_valid,
  output logic              o_busy,
  output logic [MODE_W-1:0] o_mode_id,
  output logic              o_pixel_strobe,
  output logic [CHAN_W-1:0] o_pixel_chan,
  output logic [X_W-1:0]    o_pixel_x,
  output logic [Y_W-1:0]    o_line_y,
  output logic              o_frame_done,
  output logic              o_frame_abort,
  output logic              o_cal_restart
);

  localparam logic           SIM       = (simulate != 0);
  localparam logic [Y_W-1:0] LAST_LINE = Y_W'(LINES - 1);
  localparam logic [X_W-1:0] LAST_X    = X_W'(PIX_PER_CHAN - 1);

  state_t              r_state;
  logic [MODE_W-1:0]   r_mode;
  logic [CHAN_W-1:0]   r_chan;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_line;
  logic [1:0]          r_miss;
  logic                r_busy;
  logic                r_strobe;
  logic                r_done;
  logic                r_abort;
  logic                r_cal;

  logic                w_supported;
  logic [MODE_W-1:0]   w_lookup_mode;
  logic                w_timed;
  logic [TICK_W-1:0]   w_st_len;
  logic                w_st_load;
  logic                w_st_mid;
  logic                w_st_done;
  logic [TICK_W-1:0]   w_px_len;
  logic                w_px_load;
  logic                w_px_mid;
  logic                w_px_done;
  logic                w_sync_bad;
  logic                w_sync_fail;

  assign w_supported   = (i_vis_code == VIS_M1) || (i_vis_code == VIS_S1);
  assign w_lookup_mode = (i_vis_code == VIS_S1) ? MODE_S1 : MODE_M1;
  assign w_timed       = (r_state == S_SYNC) || (r_state == S_PORCH) || (r_state == S_SCAN);

  // Length of the segment entered on the next state-timer load.
  always_comb begin
    w_st_len = mode_ticks(r_mode, SIM, TK_SYNC);
    case (r_state)
      S_LOOKUP: w_st_len = mode_ticks(w_lookup_mode, SIM, TK_SYNC);
      S_SYNC:   w_st_len = mode_ticks(r_mode, SIM, TK_PORCH);
      S_PORCH:  w_st_len = mode_ticks(r_mode, SIM, TK_SCAN);
      S_SCAN:   w_st_len = (r_chan == CHAN_W'(2)) ? mode_ticks(r_mode, SIM, TK_SYNC)
                                                  : mode_ticks(r_mode, SIM, TK_PORCH);
      default:  ;
    endcase
  end

  assign w_st_load = (r_state == S_LOOKUP) || (w_timed && w_st_done);
  assign w_px_len  = mode_ticks(r_mode, SIM, TK_PIXEL);
  assign w_px_load = ((r_state == S_PORCH) && w_st_done) || ((r_state == S_SCAN) && w_px_done);

  sstv_tick_timer u_state_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_st_load),
    .i_len    (w_st_len),
    .o_mid_c  (w_st_mid),
    .o_done_c (w_st_done)
  );

  sstv_tick_timer u_pixel_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_px_load),
    .i_len    (w_px_len),
    .o_mid_c  (w_px_mid),
    .o_done_c (w_px_done)
  );

  // Third consecutive missed sync tone at the mid-check loses the frame.
  assign w_sync_bad  = (i_freq != FREQ_1200HZ);
  assign w_sync_fail = (r_state == S_SYNC) && w_st_mid && w_sync_bad && (r_miss == 2'd2);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_mode   <= '0;
      r_chan   <= '0;
      r_x      <= '0;
      r_line   <= '0;
      r_miss   <= '0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_cal    <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_cal    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_vis_valid) begin
            r_state <= S_LOOKUP;
            r_busy  <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (w_supported) begin
            r_mode  <= w_lookup_mode;
            r_chan  <= '0;
            r_x     <= '0;
            r_line  <= '0;
            r_miss  <= '0;
            r_state <= S_SYNC;
          end else begin
            r_abort <= 1'b1;
            r_cal   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_SYNC: begin
          if (w_sync_fail) begin
            r_miss  <= r_miss + 2'd1;
            r_abort <= 1'b1;
            r_cal   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DRAIN;
          end else if (!i_vis_valid) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_st_mid) r_miss <= w_sync_bad ? (r_miss + 2'd1) : 2'd0;
            if (w_st_done) r_state <= S_PORCH;
          end
        end
        S_PORCH: begin
          if (!i_vis_valid) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_st_done) begin
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!i_vis_valid) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_px_mid) r_strobe <= 1'b1;
            if (w_st_done) begin
              r_x <= '0;
              if (r_chan == CHAN_W'(2)) begin
                r_chan <= '0;
                if (r_line == LAST_LINE) begin
                  r_state <= S_FINISH;
                end else begin
                  r_line  <= r_line + Y_W'(1);
                  r_state <= S_SYNC;
                end
              end else begin
                r_chan  <= r_chan + CHAN_W'(1);
                r_state <= S_PORCH;
              end
            end else if (w_px_done) begin
              r_x <= (r_x == LAST_X) ? '0 : r_x + X_W'(1);
            end
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_cal   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!i_vis_valid) r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_mode_id      = r_mode;
  assign o_pixel_strobe = r_strobe;
  assign o_pixel_chan   = r_chan;
  assign o_pixel_x      = r_x;
  assign o_line_y       = r_line;
  assign o_frame_done   = r_done;
  assign o_frame_abort  = r_abort;
  assign o_cal_restart  = r_cal;

endmodule

// File: doc/sstv_frame_seq.md
# sstv_frame_seq

Frame sequencer that sits downstream of the VIS decoder and calibration block. On a valid VIS code it selects a mode timing set and walks the SYNC/PORCH/SCAN schedule for every line of the frame, emitting pixel-sample strobes with channel, x and y coordinates to the pixel datapath. It supervises per-line sync and aborts lost frames. It pulses `cal_restart` to send calibration (and so VIS) back to search after a frame ends or is rejected.

## Interface
- `simulate`, 0: nonzero selects the ×1/1000 tick set for simulation.
- `LINES`, 256: lines per frame. Benches lower this to shorten runs.
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-high. All state and outputs clear immediately.
- `freq` in 12: measured tone in Hz, from the frequency estimator.
- `vis_code` in 7: decoded VIS code. Meaningful only while `vis_valid` is high.
- `vis_valid` in 1: high from VIS lock until calibration drops.
- `busy` out 1: high in every state except IDLE and DRAIN.
- `mode_id` out 2: 0 = Martin M1, 1 = Scottie S1. Held from LOOKUP until the next LOOKUP.
- `pixel_strobe` out 1: one-cycle pulse at the centre of each pixel period.
- `pixel_chan` out 2: channel 0..2 being scanned.
- `pixel_x` out 9: pixel index 0..319.
- `line_y` out 8: line index 0..LINES-1.
- `frame_done` out 1: one-cycle pulse after the last pixel of the last line.
- `frame_abort` out 1: one-cycle pulse on a sync-loss abort or an unsupported VIS code.
- `cal_restart` out 1: one-cycle pulse that requests recalibration.
- Reset values: all outputs 0.

## Operation
- States: IDLE, LOOKUP, SYNC, PORCH, SCAN, FINISH, DRAIN. One-hot encoding.
- IDLE → LOOKUP on `vis_valid`=1.
- LOOKUP takes 1 cycle:
  - `vis_code` 7'd44 → mode 0.
  - `vis_code` 7'd60 → mode 1.
  - Any other code → pulse `frame_abort` and `cal_restart`, then go to DRAIN.
  - Supported code → clear line and channel counters, clear `sync_miss`, go to SYNC.
- Every timed state lasts exactly N cycles. The tick counter loads 1 on entry and the state exits on the cycle the counter equals N.
- Tick table (real / simulate):
  - Mode 0: sync 486_200/486, porch 57_200/57, pixel 45_760/45.
  - Mode 1: sync 900_000/900, porch 150_000/150, pixel 43_200/43.
  - SCAN length = 320 × pixel ticks.
- Per-line sequence: SYNC, then (PORCH, SCAN) for channels 0, 1, 2.
- SYNC mid-check at tick sync/2 (integer division):
  - `freq`==1200 → `sync_miss` clears to 0.
  - Otherwise `sync_miss` increments (2-bit counter).
  - If it reaches 3 → pulse `frame_abort` and `cal_restart`, then go to DRAIN immediately.
- SCAN: `pixel_strobe` on pixel tick pixel/2 of each pixel period. `pixel_x` increments at each pixel-period end and wraps 319→0 at SCAN exit.
- SCAN exit routing:
  - Channel 2 and last line → FINISH.
  - Channel 2, not last line → next line, SYNC.
  - Otherwise → next channel, PORCH.
- FINISH takes 1 cycle: pulse `frame_done` and `cal_restart`, then go to DRAIN.
- DRAIN: stay until `vis_valid`=0, then go to IDLE. This prevents re-triggering on a stale VIS.
- `vis_valid` falling in SYNC/PORCH/SCAN: go to IDLE next cycle with no pulses. Calibration has already restarted itself.
- Simultaneous events: on the same cycle, abort takes priority over `vis_valid` loss.

## Timing
- `pixel_strobe`, `pixel_chan`, `pixel_x` and `line_y` are all registered and aligned in the same cycle.
- First strobe of a frame (counting from the LOOKUP cycle): 1 + sync + porch + pixel/2 cycles after LOOKUP.
- `frame_done`, `frame_abort` and `cal_restart` are registered single-cycle pulses. Never two in a row.
- Reset mid-frame returns to IDLE with no pulses issued.

## Structure
- Package `sstv_pkg`:
  - State encoding localparams.
  - Mode ids.
  - VIS constants 44 and 60.
  - FREQ_1200HZ.
  - Per-mode sync/porch/pixel tick constants for both simulate settings.
  - Pixels-per-channel (320).
- Sub-module `sstv_tick_timer`:
  - Loadable 32-bit down-counter with `load`, `len` and `mid`/`done` flags.
  - Shared by the state timer; a second instance serves as the pixel timer.

## Test plan
- `simulate`=1, `LINES`=2, VIS 44, `freq` 1200 during every SYNC → 1920 strobes, `mode_id`=0. Then one `frame_done`, a simultaneous `cal_restart`, then DRAIN until `vis_valid` drops.
- VIS 60 → first strobe exactly 1+900+150+21 cycles after LOOKUP, with `pixel_chan`=0, `pixel_x`=0, `line_y`=0.
- VIS 7'd8 (unsupported) → `frame_abort` and `cal_restart` on the cycle after LOOKUP, no strobes, `busy`=0.
- `LINES`=8, `freq` 1500 during SYNC of lines 2, 3 and 4 → abort at the mid-check of line 4, no `frame_done`. A single bad sync (line 2 only) → frame completes.
- `vis_valid` deasserted mid-SCAN of line 1 → IDLE next cycle, no pulses. Re-asserted → new frame starts from `line_y`=0.
- Async `reset` asserted between clock edges mid-SCAN → all outputs 0 before the next edge. Released → IDLE.
